// File: rtl/event_pkg.sv
// Shared types and constants for the event serializer slice.
package event_pkg;

  localparam int unsigned COORD_W = 2;
  localparam int unsigned EVT_W   = 8;
  localparam int unsigned BEATS   = 4;

  // One filtered event; x lands in the most significant bits.
  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] t;
    logic [COORD_W-1:0] p;
  } event_t;

  typedef enum logic {IDLE, SEND} state_t;

  typedef logic [1:0] beat_t;

  localparam beat_t LAST_BEAT = beat_t'(BEATS - 1);

  // Field carried on a given beat: x, y, t, p for beats 0..3.
  function automatic logic [COORD_W-1:0] beat_field(input event_t e, input beat_t b);
    logic [COORD_W-1:0] f;
    f = e.x;
    case (b)
      2'd1:    f = e.y;
      2'd2:    f = e.t;
      2'd3:    f = e.p;
      default: f = e.x;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/event_fifo.sv
// Synchronous FIFO; a write into a full FIFO is accepted only alongside a read.
module event_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic                     rd_en,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr_ok;
  logic          rd_ok;

  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);
  assign rd_ok = rd_en && !empty;
  assign wr_ok = wr_en && (!full || rd_ok);
  assign dout  = mem[rd_ptr];

  // Storage array; contents need no reset since level gates every read.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/event_serializer.sv
// Buffers filtered events and streams each as four 2-bit beats with framing.
module event_serializer
  import event_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DROP_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [1:0]              x_in,
  input  logic [1:0]              y_in,
  input  logic [1:0]              t_in,
  input  logic [1:0]              p_in,
  input  logic                    clr_stats,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic [1:0]              out_data,
  output logic                    out_sof,
  output logic                    out_eof,
  output logic [$clog2(DEPTH):0]  fifo_level,
  output logic [DROP_W-1:0]       drop_count,
  output logic                    overflow
);

  state_t     state_q, state_d;
  beat_t      beat_q, beat_d;
  event_t     evt_q, evt_d;
  event_t     in_evt;
  event_t     fifo_dout;
  logic       fifo_full;
  logic       fifo_empty;
  logic       frame_done;
  logic       pop;
  logic       wr_en;
  logic       drop;
  logic       load;
  logic       valid_d;
  logic [1:0] data_d;
  logic       sof_d;
  logic       eof_d;

  assign in_evt     = {x_in, y_in, t_in, p_in};
  assign frame_done = (state_q == SEND) && out_ready && (beat_q == LAST_BEAT);
  assign pop        = !fifo_empty && ((state_q == IDLE) || frame_done);
  assign wr_en      = in_valid && (!fifo_full || pop);
  assign drop       = in_valid && fifo_full && !pop;

  event_fifo #(
    .DEPTH (DEPTH),
    .W     (EVT_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .wr_en (wr_en),
    .rd_en (pop),
    .din   (in_evt),
    .dout  (fifo_dout),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Next state, beat counter, shift register and output values.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    evt_d   = evt_q;
    valid_d = out_valid;
    data_d  = out_data;
    sof_d   = out_sof;
    eof_d   = out_eof;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (pop) load = 1'b1;
      end
      SEND: begin
        if (out_ready) begin
          if (beat_q != LAST_BEAT) begin
            beat_d = beat_t'(beat_q + 2'd1);
            data_d = beat_field(evt_q, beat_d);
            sof_d  = 1'b0;
            eof_d  = (beat_d == LAST_BEAT);
          end else if (pop) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
            valid_d = 1'b0;
            data_d  = '0;
            sof_d   = 1'b0;
            eof_d   = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      state_d = SEND;
      evt_d   = fifo_dout;
      beat_d  = '0;
      valid_d = 1'b1;
      data_d  = beat_field(fifo_dout, '0);
      sof_d   = 1'b1;
      eof_d   = 1'b0;
    end
  end

  // FSM, shift register and registered output bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      evt_q     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      evt_q     <= evt_d;
      out_valid <= valid_d;
      out_data  <= data_d;
      out_sof   <= sof_d;
      out_eof   <= eof_d;
    end
  end

  // Saturating drop counter and sticky overflow; a same-cycle drop wins over clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_count <= '0;
      overflow   <= 1'b0;
    end else if (clr_stats) begin
      drop_count <= drop ? DROP_W'(1) : '0;
      overflow   <= drop;
    end else if (drop) begin
      if (drop_count != '1) drop_count <= drop_count + DROP_W'(1);
      overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_event_serializer.sv
// Directed bench for event_serializer with a queue-based reference model.
module tb_event_serializer;

  localparam int DEPTH  = 4;
  localparam int DROP_W = 8;
  localparam int DMAX   = 255;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [1:0] x_in, y_in, t_in, p_in;
  logic       clr_stats;
  logic       out_ready;
  logic       out_valid;
  logic [1:0] out_data;
  logic       out_sof;
  logic       out_eof;
  logic [2:0] fifo_level;
  logic [7:0] drop_count;
  logic       overflow;

  int n_vec = 0;
  int n_err = 0;

  event_serializer #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .x_in       (x_in),
    .y_in       (y_in),
    .t_in       (t_in),
    .p_in       (p_in),
    .clr_stats  (clr_stats),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_sof    (out_sof),
    .out_eof    (out_eof),
    .fifo_level (fifo_level),
    .drop_count (drop_count),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: pending events in a queue plus the event currently on the wire.
  logic [7:0] mq[$];
  bit         m_active;
  logic [7:0] m_evt;
  int         m_beat;
  int         m_dc;
  bit         m_ov;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_active = 0;
      m_evt    = '0;
      m_beat   = 0;
      m_dc     = 0;
      m_ov     = 0;
    end else begin
      bit         full, popping, dropping;
      logic [7:0] head;
      full     = (mq.size() == DEPTH);
      popping  = (mq.size() > 0) && (!m_active || (m_beat == 3 && out_ready));
      dropping = in_valid && full && !popping;
      head     = '0;
      if (popping) head = mq.pop_front();
      if (in_valid && !dropping) mq.push_back({x_in, y_in, t_in, p_in});
      if (popping) begin
        m_active = 1;
        m_evt    = head;
        m_beat   = 0;
      end else if (m_active && out_ready) begin
        if (m_beat < 3) m_beat++;
        else m_active = 0;
      end
      if (clr_stats) begin
        m_dc = dropping ? 1 : 0;
        m_ov = dropping;
      end else if (dropping) begin
        m_dc = (m_dc < DMAX) ? m_dc + 1 : DMAX;
        m_ov = 1;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      int exp_data;
      exp_data = m_active ? int'((m_evt >> (6 - 2 * m_beat)) & 8'h03) : 0;
      chk("m_valid", int'(out_valid), int'(m_active));
      chk("m_data",  int'(out_data),  exp_data);
      chk("m_sof",   int'(out_sof),   int'(m_active && m_beat == 0));
      chk("m_eof",   int'(out_eof),   int'(m_active && m_beat == 3));
      chk("m_level", int'(fifo_level), mq.size());
      chk("m_drops", int'(drop_count), m_dc);
      chk("m_ovf",   int'(overflow),  int'(m_ov));
    end
  end

  task automatic send(input logic [1:0] x, input logic [1:0] y,
                      input logic [1:0] t, input logic [1:0] p);
    in_valid = 1'b1;
    x_in = x; y_in = y; t_in = t; p_in = p;
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int seq3 [8];
    seq3 = '{0, 1, 2, 3, 2, 3, 0, 1};

    rst_n = 1'b0; in_valid = 1'b0; x_in = '0; y_in = '0; t_in = '0; p_in = '0;
    clr_stats = 1'b0; out_ready = 1'b1;
    #1;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_level", int'(fifo_level), 0);
    chk("rst_drops", int'(drop_count), 0);
    nxt(); nxt();
    rst_n = 1'b1;
    nxt();

    // Single event 3,1,2,1 with out_ready high.
    send(2'd3, 2'd1, 2'd2, 2'd1);
    nxt(); in_valid = 1'b0;
    chk("t1_level", int'(fifo_level), 1);
    chk("t1_idle", int'(out_valid), 0);
    nxt(); chk("t1_b0", int'(out_data), 3); chk("t1_sof", int'(out_sof), 1);
    nxt(); chk("t1_b1", int'(out_data), 1);
    nxt(); chk("t1_b2", int'(out_data), 2);
    nxt(); chk("t1_b3", int'(out_data), 1); chk("t1_eof", int'(out_eof), 1);
    nxt(); chk("t1_done", int'(out_valid), 0);

    // Same event, stalled three cycles on beat 1.
    send(2'd3, 2'd1, 2'd2, 2'd1);
    nxt(); in_valid = 1'b0;
    nxt();
    nxt(); chk("t2_b1", int'(out_data), 1); out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      nxt();
      chk("t2_hold_data", int'(out_data), 1);
      chk("t2_hold_valid", int'(out_valid), 1);
    end
    out_ready = 1'b1;
    nxt(); chk("t2_b2", int'(out_data), 2);
    nxt(); chk("t2_b3", int'(out_data), 1);
    nxt(); chk("t2_done", int'(out_valid), 0);

    // Two back-to-back events: eight contiguous beats.
    send(2'd0, 2'd1, 2'd2, 2'd3);
    nxt(); send(2'd2, 2'd3, 2'd0, 2'd1);
    nxt(); in_valid = 1'b0;
    chk("t3_level1", int'(fifo_level), 1);
    for (int i = 0; i < 8; i++) begin
      chk("t3_valid", int'(out_valid), 1);
      chk("t3_data", int'(out_data), seq3[i]);
      nxt();
    end
    chk("t3_level0", int'(fifo_level), 0);
    chk("t3_done", int'(out_valid), 0);

    // Six writes while stalled: four buffered, one in flight, one dropped.
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      send(2'(i), 2'(i + 1), 2'(i + 2), 2'd3);
      nxt();
    end
    in_valid = 1'b0;
    chk("t4_level", int'(fifo_level), 4);
    chk("t4_drops", int'(drop_count), 1);
    chk("t4_ovf", int'(overflow), 1);

    // Write into a full FIFO on the beat-3 handshake is not a drop.
    out_ready = 1'b1;
    nxt(); nxt(); nxt();
    chk("t5_eof", int'(out_eof), 1);
    send(2'd1, 2'd3, 2'd1, 2'd3);
    nxt(); in_valid = 1'b0;
    chk("t5_level", int'(fifo_level), 4);
    chk("t5_drops", int'(drop_count), 1);
    chk("t5_sof", int'(out_sof), 1);

    // Saturate the drop counter, then clear statistics.
    out_ready = 1'b0;
    send(2'd2, 2'd2, 2'd2, 2'd2);
    repeat (300) nxt();
    in_valid = 1'b0;
    chk("t5_sat", int'(drop_count), 255);
    chk("t5_ovf", int'(overflow), 1);
    clr_stats = 1'b1;
    nxt(); clr_stats = 1'b0;
    chk("t5_clr_drops", int'(drop_count), 0);
    chk("t5_clr_ovf", int'(overflow), 0);
    out_ready = 1'b1;
    repeat (30) nxt();
    chk("t5_drained", int'(fifo_level), 0);

    // Asynchronous reset in the middle of a frame.
    send(2'd1, 2'd2, 2'd3, 2'd0);
    nxt(); in_valid = 1'b0;
    nxt(); nxt();
    nxt(); chk("t6_b2", int'(out_data), 3);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_valid", int'(out_valid), 0);
    chk("t6_data", int'(out_data), 0);
    chk("t6_sof", int'(out_sof), 0);
    chk("t6_eof", int'(out_eof), 0);
    chk("t6_level", int'(fifo_level), 0);
    nxt(); rst_n = 1'b1;
    nxt();
    send(2'd2, 2'd0, 2'd1, 2'd3);
    nxt(); in_valid = 1'b0;
    nxt(); chk("t6_new_b0", int'(out_data), 2); chk("t6_new_sof", int'(out_sof), 1);
    nxt(); chk("t6_new_b1", int'(out_data), 0);
    repeat (4) nxt();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/event_serializer.md
Name: event_serializer

Overview:
- Downstream of the event filter stage. Accepts one filtered event per cycle: x, y, t and p, each 2 bits.
- Buffers events in a small FIFO, then serializes each event onto a 2-bit output bus as 4 beats with valid/ready handshake and frame markers.
- Absorbs bursts and off-chip backpressure; counts events dropped on overflow.

Parameters:
- DEPTH, 4, FIFO depth in events; power of two, ≥2.
- DROP_W, 8, width of saturating drop counter.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  event present on x_in/y_in/t_in/p_in this cycle
- x_in  input  2  event x coordinate
- y_in  input  2  event y coordinate
- t_in  input  2  event timestamp
- p_in  input  2  event polarity
- clr_stats  input  1  synchronous clear of drop_count and overflow
- out_ready  input  1  consumer accepts current beat
- out_valid  output  1  out_data holds a valid beat
- out_data  output  2  serialized beat
- out_sof  output  1  high on beat 0 of an event
- out_eof  output  1  high on beat 3 of an event
- fifo_level  output  $clog2(DEPTH)+1  events stored, excluding the one being sent
- drop_count  output  DROP_W  events dropped because the FIFO was full; saturating
- overflow  output  1  sticky; set on first drop

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: out_valid=0, out_data=0, out_sof=0, out_eof=0, fifo_level=0, drop_count=0, overflow=0.
  - FIFO pointers are zeroed and the FSM returns to IDLE.
  - Reset mid-frame abandons the frame. There is no partial replay.
- Event word: {x_in, y_in, t_in, p_in}, 8 bits; x occupies bits 7:6.
- Pop: the FSM is in IDLE, or in SEND with beat 3 accepted (out_ready=1), and the FIFO is non-empty.
- Write: in_valid && (!full || pop). A write to a full FIFO is permitted in the same cycle as a pop.
  - Level is unchanged on a simultaneous write and pop.
  - Level +1 on a write alone; -1 on a pop alone.
- Drop: in_valid && full && !pop.
  - drop_count increments, saturating at 2^DROP_W-1. overflow is set.
  - The dropped event is lost; FIFO contents are unchanged.
- clr_stats: drop_count and overflow are cleared next edge. If a drop occurs in the same cycle, the result is drop_count=1 and overflow=1.
- FSM states and transitions:
  - IDLE: out_valid=0. On pop: load the shift register, beat=0, go to SEND.
  - SEND: out_valid=1.
    - out_data = x, y, t, p for beats 0,1,2,3 respectively.
    - out_sof = (beat==0); out_eof = (beat==3).
    - out_ready=1 and beat<3: beat+1.
    - out_ready=1 and beat==3: if pop, load the next event with beat=0 and stay in SEND (back-to-back, no bubble); else go to IDLE.
    - out_ready=0: hold all outputs stable.
- Latency: an event written at edge N into an empty FIFO while in IDLE gives out_valid=1 with beat 0 after edge N+1.
- Throughput: with out_ready held high, 1 event per 4 cycles. A sustained input rate above 1/4 therefore drops events.
- FIFO ordering is strict FIFO; pointers wrap modulo DEPTH. full is (level==DEPTH); empty is (level==0).
- All outputs are registered.

Decomposition:
- Package event_pkg:
  - constants COORD_W=2, EVT_W=8, BEATS=4
  - typedef for the event word struct {x,y,t,p}
  - enum for FSM state {IDLE, SEND}
  - beat index typedef (2 bits)
- Sub-module event_fifo: parameterised synchronous FIFO with wr_en, rd_en, din, dout, level, full and empty. It uses async active-low reset and allows write when full only with a simultaneous read.
- event_serializer holds the FSM, shift register and statistics.

Test Plan:
- Single event x=3,y=1,t=2,p=1, out_ready=1 → out_data 3,1,2,1 on 4 consecutive cycles. out_sof on the first beat, out_eof on the fourth. Then out_valid=0.
- Same event with out_ready low for 3 cycles at beat 1 → out_data holds 1 with out_valid=1 while stalled. The frame then completes in order.
- Two events on consecutive cycles, out_ready=1 → 8 contiguous beats with no out_valid gap. fifo_level goes 1 then 0.
- out_ready=0 while 6 events are written with DEPTH=4 → fifo_level=4 (one event held in the shift register). drop_count=1 and overflow=1; the 6th event does not appear on the output.
- Full FIFO with in_valid on the same cycle beat 3 is accepted → no drop and fifo_level unchanged. 300 forced drops → drop_count=255. Then clr_stats → drop_count=0, overflow=0.
- rst_n asserted during beat 2 → all outputs 0 immediately without waiting for clk. After release, a new event serializes starting at beat 0.
